// File: rtl/psram_burst_writer.sv
// Ping-pong burst buffer feeding the PSRAM command port: collects BURST_WORDS pixel words per
// bank and issues each full bank as one write burst, spaced at least CMD_CYCLES apart.
module psram_burst_writer #(
  parameter int          BURST_WORDS  = 8,
  parameter int          CMD_CYCLES   = 19,
  parameter int          ADDR_STEP    = 16,
  parameter logic [20:0] FRAME_BASE   = 21'd0,
  parameter int          FRAME_BURSTS = 4800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        frame_start,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        cmd,
  output logic        cmd_en,
  output logic [20:0] addr,
  output logic [31:0] wr_data,
  output logic [3:0]  data_mask,
  output logic        frame_done,
  output logic        busy
);

  localparam int BW = $clog2(BURST_WORDS);
  localparam int CW = $clog2(CMD_CYCLES + 1);

  localparam logic [BW-1:0] LAST_BEAT   = BW'(BURST_WORDS - 1);
  localparam logic [CW-1:0] CMD_SAT     = CW'(CMD_CYCLES);
  localparam logic [CW-1:0] GAP_READY   = CW'(CMD_CYCLES - 1);
  localparam logic [12:0]   LAST_BURST  = 13'(FRAME_BURSTS - 1);
  localparam logic [12:0]   FRAME_LIMIT = 13'(FRAME_BURSTS);
  localparam logic [20:0]   STEP        = 21'(ADDR_STEP);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_GAP} state_t;

  state_t        state, state_n;
  logic [BW-1:0] beat;
  logic [CW-1:0] cyc_since;
  logic [20:0]   pointer;
  logic [12:0]   burst_cnt;
  logic [12:0]   filled_cnt;
  logic [BW-1:0] fill_cnt;
  logic          fill_sel, fill_sel_n;
  logic          issue_sel;
  logic [1:0]    bank_full, bank_full_n;
  logic          stale;
  logic          frame_done_q;

  logic [31:0]   mem [2][BURST_WORDS];

  logic fs_eff, accept, full_set, issuing, last_beat, drain;
  logic stale_now, final_burst, ok_next, can_issue;

  // A frame_start in IDLE without calibration is ignored; once busy it always restarts the frame.
  assign fs_eff      = frame_start && ((state != S_IDLE) || init_done);
  assign busy        = (state != S_IDLE);
  assign in_ready    = busy && !bank_full[fill_sel] && (filled_cnt < FRAME_LIMIT);
  assign accept      = in_valid && in_ready && !frame_start;
  assign full_set    = accept && (fill_cnt == LAST_BEAT);
  assign issuing     = (state == S_ISSUE);
  assign last_beat   = issuing && (beat == LAST_BEAT);
  assign drain       = last_beat;
  assign stale_now   = stale || fs_eff;
  assign final_burst = (burst_cnt == LAST_BURST);
  // True when a command strobe on the next cycle keeps the CMD_CYCLES spacing.
  assign ok_next     = (cyc_since >= GAP_READY);
  assign can_issue   = bank_full[issue_sel] && init_done && ok_next && !fs_eff;

  assign cmd_en      = issuing && (beat == '0);
  assign cmd         = cmd_en;
  assign addr        = cmd_en ? pointer : 21'd0;
  assign wr_data     = issuing ? mem[issue_sel][beat] : 32'd0;
  assign data_mask   = 4'b0000;
  assign frame_done  = frame_done_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    bank_full_n = bank_full;
    fill_sel_n  = fill_sel;
    if (fs_eff) begin
      // Flush everything except a bank whose burst is still on the wire.
      bank_full_n = 2'b00;
      if (issuing && !last_beat) bank_full_n[issue_sel] = 1'b1;
      fill_sel_n = issuing ? ~issue_sel : issue_sel;
    end else begin
      if (full_set) bank_full_n[fill_sel] = 1'b1;
      if (drain)    bank_full_n[issue_sel] = 1'b0;
      if (bank_full_n[fill_sel] && !bank_full_n[~fill_sel]) fill_sel_n = ~fill_sel;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (fs_eff) state_n = S_WAIT;
      S_WAIT:  if (can_issue) state_n = S_ISSUE;
      S_ISSUE: if (last_beat) state_n = (final_burst && !stale_now) ? S_IDLE : S_GAP;
      S_GAP: begin
        if (can_issue)    state_n = S_ISSUE;
        else if (ok_next) state_n = S_WAIT;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      beat         <= '0;
      cyc_since    <= CMD_SAT;
      pointer      <= FRAME_BASE;
      burst_cnt    <= '0;
      filled_cnt   <= '0;
      fill_cnt     <= '0;
      fill_sel     <= 1'b0;
      issue_sel    <= 1'b0;
      bank_full    <= 2'b00;
      stale        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state     <= state_n;
      beat      <= (issuing && !last_beat) ? beat + 1'b1 : '0;
      cyc_since <= cmd_en ? CW'(1) : ((cyc_since < CMD_SAT) ? cyc_since + 1'b1 : cyc_since);

      if (fs_eff) begin
        pointer   <= FRAME_BASE;
        burst_cnt <= '0;
      end else if (drain && !stale) begin
        pointer   <= pointer + STEP;
        burst_cnt <= burst_cnt + 1'b1;
      end

      // A burst interrupted by frame_start belongs to the old frame and must not advance the new one.
      if (fs_eff && issuing) stale <= 1'b1;
      else if (!issuing)     stale <= 1'b0;

      frame_done_q <= drain && final_burst && !stale_now;

      bank_full <= bank_full_n;
      fill_sel  <= fill_sel_n;
      if (drain) issue_sel <= ~issue_sel;

      if (fs_eff) begin
        fill_cnt   <= '0;
        filled_cnt <= '0;
      end else if (accept) begin
        fill_cnt <= full_set ? '0 : fill_cnt + 1'b1;
        if (full_set) filled_cnt <= filled_cnt + 1'b1;
      end
    end
  end

  // NOTE: the bank storage has no reset; bank_full and fill_cnt decide which contents are live.
  always_ff @(posedge clk) begin
    if (accept) mem[fill_sel][fill_cnt] <= in_data;
  end

endmodule
